switch_mailbox: RTL

Switch-side endpoint facing one MatCore's switch port. It is the responder for the core's send and receive handshakes. Core sends are captured into an outbound slot toward the switch fabric. Vectors arriving from the fabric are buffered in one FIFO per source core and handed out when the core requests that source. One instance sits between each MatCore and the switch fabric.

---
 rtl/switch_mailbox.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/switch_mailbox.sv
// switch_mailbox: switch-side endpoint for one MatCore's switch port.
// Responds to the core's send and receive handshakes. A core send is captured
// into a single outbound slot toward the fabric. Vectors arriving from the
// fabric are buffered in one FIFO per source core and handed to the core when
// it requests that source.
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-low reset
//   switch_send_ready/_core_idx/_data   core send request (held until switch_send_ok)
//   switch_send_ok               one-cycle pulse, send accepted
//   switch_recv_request/_core_idx       core receive request (held until switch_recv_ready)
//   switch_recv_ready            one-cycle pulse, switch_recv_data valid
//   switch_recv_data             last popped vector (held between pops)
//   net_out_valid/_dst/_data     outbound slot toward the fabric
//   net_out_ready                fabric accepts the outbound vector
//   net_in_valid/_src/_data      inbound vector from the fabric
//   net_in_ready                 combinational: inbound accepted this cycle
//
// Build option: define SWITCH_MAILBOX_LOOPBACK_EN to route sends addressed to
// SELF_IDX straight into FIFO[SELF_IDX] instead of the outbound slot.

module switch_mailbox #(
    parameter int unsigned SWITCH_CORE_SIZE      = 4,
    parameter int unsigned SWITCH_WIDTH          = 16,
    parameter int unsigned ELEM_WIDTH            = 32,
    parameter int unsigned FIFO_DEPTH            = 4,
    parameter int unsigned SELF_IDX              = 0,
    parameter int unsigned SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 switch_send_ready,
    input  logic [SWITCH_CORE_ADDR_SIZE-1:0]     switch_send_core_idx,
    input  logic [SWITCH_WIDTH*ELEM_WIDTH-1:0]   switch_send_data,
    output logic                                 switch_send_ok,
    input  logic                                 switch_recv_request,
    input  logic [SWITCH_CORE_ADDR_SIZE-1:0]     switch_recv_core_idx,
    output logic                                 switch_recv_ready,
    output logic [SWITCH_WIDTH*ELEM_WIDTH-1:0]   switch_recv_data,
    output logic                                 net_out_valid,
    output logic [SWITCH_CORE_ADDR_SIZE-1:0]     net_out_dst,
    output logic [SWITCH_WIDTH*ELEM_WIDTH-1:0]   net_out_data,
    input  logic                                 net_out_ready,
    input  logic                                 net_in_valid,
    input  logic [SWITCH_CORE_ADDR_SIZE-1:0]     net_in_src,
    input  logic [SWITCH_WIDTH*ELEM_WIDTH-1:0]   net_in_data,
    output logic                                 net_in_ready
);

    localparam int unsigned VEC_W  = SWITCH_WIDTH * ELEM_WIDTH;
    localparam int unsigned ADDR_W = SWITCH_CORE_ADDR_SIZE;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W-1:0] SELF_ADDR = ADDR_W'(SELF_IDX);

`ifdef SWITCH_MAILBOX_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    // Per-source FIFO storage and bookkeeping
    logic [VEC_W-1:0] mem    [SWITCH_CORE_SIZE][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [SWITCH_CORE_SIZE];
    logic [PTR_W-1:0] rd_ptr [SWITCH_CORE_SIZE];
    logic [CNT_W-1:0] cnt    [SWITCH_CORE_SIZE];

    logic [SWITCH_CORE_SIZE-1:0] full;
    logic [SWITCH_CORE_SIZE-1:0] push_en;
    logic [SWITCH_CORE_SIZE-1:0] pop_en;
    logic [VEC_W-1:0]            wr_data [SWITCH_CORE_SIZE];
    logic [VEC_W-1:0]            pop_data;
    logic                        send_accept;
    logic                        lb_push;
    logic                        slot_load;

    // Full flags come from registered counts only
    always_comb begin
        full = '0;
        for (int i = 0; i < SWITCH_CORE_SIZE; i++) begin
            full[i] = (cnt[i] == CNT_W'(FIFO_DEPTH));
        end
    end

    // Inbound acceptance; an out-of-range source matches no FIFO and is accepted then dropped
    always_comb begin
        net_in_ready = 1'b1;
        for (int i = 0; i < SWITCH_CORE_SIZE; i++) begin
            if (net_in_src == ADDR_W'(i)) begin
                net_in_ready = !full[i];
            end
        end
        if (LOOPBACK && (net_in_src == SELF_ADDR)) begin
            net_in_ready = 1'b0;
        end
    end

    // Send acceptance; the pulse term blocks a held request from being taken twice
    always_comb begin
        lb_push     = 1'b0;
        send_accept = switch_send_ready && !switch_send_ok && !net_out_valid;
        if (LOOPBACK && (switch_send_core_idx == SELF_ADDR)) begin
            send_accept = switch_send_ready && !switch_send_ok && !full[SELF_IDX];
            lb_push     = send_accept;
        end
        slot_load = send_accept && !lb_push;
    end

    // Push/pop decode and write-data select per FIFO
    always_comb begin
        push_en  = '0;
        pop_en   = '0;
        pop_data = '0;
        for (int i = 0; i < SWITCH_CORE_SIZE; i++) begin
            wr_data[i] = net_in_data;
            push_en[i] = net_in_valid && net_in_ready && (net_in_src == ADDR_W'(i));
            pop_en[i]  = switch_recv_request && !switch_recv_ready &&
                         (switch_recv_core_idx == ADDR_W'(i)) && (cnt[i] != '0);
            if (pop_en[i]) begin
                pop_data = mem[i][rd_ptr[i]];
            end
        end
        if (lb_push) begin
            push_en[SELF_IDX] = 1'b1;
            wr_data[SELF_IDX] = switch_send_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SWITCH_CORE_SIZE; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < SWITCH_CORE_SIZE; i++) begin
                if (push_en[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop_en[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                case ({push_en[i], pop_en[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // FIFO storage; contents are meaningless while the count says empty
    always_ff @(posedge clock) begin
        for (int i = 0; i < SWITCH_CORE_SIZE; i++) begin
            if (push_en[i]) begin
                mem[i][wr_ptr[i]] <= wr_data[i];
            end
        end
    end

    // Handshake pulses, receive data and outbound slot
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            switch_send_ok    <= 1'b0;
            switch_recv_ready <= 1'b0;
            switch_recv_data  <= '0;
            net_out_valid     <= 1'b0;
            net_out_dst       <= '0;
            net_out_data      <= '0;
        end else begin
            switch_send_ok    <= send_accept;
            switch_recv_ready <= |pop_en;
            if (|pop_en) begin
                switch_recv_data <= pop_data;
            end
            // Load only happens with the slot empty, so drain and refill never share an edge
            if (slot_load) begin
                net_out_valid <= 1'b1;
                net_out_dst   <= switch_send_core_idx;
                net_out_data  <= switch_send_data;
            end else if (net_out_valid && net_out_ready) begin
                net_out_valid <= 1'b0;
            end
        end
    end

endmodule
